// File: rtl/afu_csr_pkg.sv
// Shared types for the AFU MMIO CSR block: CCI-P MMIO views, CSR map and read-request struct.
// Only the CCI-P fields the CSR responder touches are modelled here.
package afu_csr_pkg;

    typedef logic [15:0] t_csr_dw_addr;

    typedef enum logic [1:0] {
        MMIO_LEN_4B   = 2'd0,
        MMIO_LEN_8B   = 2'd1,
        MMIO_LEN_64B  = 2'd2,
        MMIO_LEN_RSVD = 2'd3
    } t_mmio_len;

    typedef struct packed {
        t_csr_dw_addr address;
        logic [1:0]   length;
        logic         rsvd;
        logic [8:0]   tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    localparam logic [15:0] CSR_DFH       = 16'h000;
    localparam logic [15:0] CSR_ID_L      = 16'h008;
    localparam logic [15:0] CSR_ID_H      = 16'h010;
    localparam logic [15:0] CSR_SCRATCH   = 16'h028;
    localparam logic [15:0] CSR_CTL       = 16'h030;
    localparam logic [15:0] CSR_SRC_ADDR  = 16'h038;
    localparam logic [15:0] CSR_DST_ADDR  = 16'h040;
    localparam logic [15:0] CSR_NUM_LINES = 16'h048;
    localparam logic [15:0] CSR_STATUS    = 16'h050;
    localparam logic [15:0] CSR_CYCLE_CNT = 16'h058;
    localparam logic [15:0] CSR_MMIO_CNT  = 16'h060;

    localparam int unsigned CTL_START_BIT   = 0;
    localparam int unsigned STATUS_DONE_BIT = 0;
    localparam int unsigned STATUS_ERR_BIT  = 1;

    typedef struct packed {
        logic         valid;
        logic [8:0]   tid;
        t_csr_dw_addr dw_addr;
        t_mmio_len    len;
    } t_csr_rd_req;

    // 64-bit register index of a byte offset, comparable with dw_addr[15:1].
    function automatic logic [14:0] csr_qw(input logic [15:0] byte_off);
        return {2'b00, byte_off[15:3]};
    endfunction

endpackage

// File: rtl/afu_mmio_rsp_pipe.sv
// Two-stage MMIO read response pipeline: stage 1 captures the selected CSR, stage 2 places
// the requested DW and registers the c2 response.
module afu_mmio_rsp_pipe
    import afu_csr_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  t_csr_rd_req    rd_req,
    input  logic [63:0]    rd_data,
    output t_if_ccip_c2_Tx c2_tx
);

    t_csr_rd_req s1_req;
    logic [63:0] s1_data;
    logic [63:0] s2_data;

    always_comb begin
        s2_data = s1_data;
        if (s1_req.len == MMIO_LEN_4B) begin
            s2_data = s1_req.dw_addr[0] ? {32'b0, s1_data[63:32]} : {32'b0, s1_data[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_req  <= '0;
            s1_data <= '0;
            c2_tx   <= '0;
        end else begin
            s1_req            <= rd_req;
            s1_data           <= rd_data;
            c2_tx.mmioRdValid <= s1_req.valid;
            c2_tx.hdr.tid     <= s1_req.tid;
            c2_tx.data        <= s2_data;
        end
    end

    logic unused_addr;
    assign unused_addr = ^s1_req.dw_addr[15:1];

endmodule

// File: rtl/afu_mmio_csr.sv
// AFU MMIO CSR responder: decodes CCI-P c0 MMIO reads/writes, holds DFH/ID and control CSRs.
// Optional performance counters (CYCLE_CNT, MMIO_CNT) enabled by AFU_CSR_PERF_CNT_EN.
module afu_mmio_csr
    import afu_csr_pkg::*;
#(
    parameter logic [63:0] AFU_DFH  = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L = 64'h0,
    parameter logic [63:0] AFU_ID_H = 64'h0,
    parameter int unsigned NLINES_W = 32
) (
    input  logic                Clk_400,
    input  logic                SoftReset,
    input  t_if_ccip_Rx         cp2af_sRxPort,
    output t_if_ccip_c2_Tx      mmio_c2Tx,
    output logic                ctl_start,
    output logic [63:0]         ctl_reg,
    output logic [63:0]         src_addr,
    output logic [63:0]         dst_addr,
    output logic [NLINES_W-1:0] num_lines,
    input  logic                stat_done,
    input  logic                stat_err
);

    localparam logic [14:0] QW_DFH       = csr_qw(CSR_DFH);
    localparam logic [14:0] QW_ID_L      = csr_qw(CSR_ID_L);
    localparam logic [14:0] QW_ID_H      = csr_qw(CSR_ID_H);
    localparam logic [14:0] QW_SCRATCH   = csr_qw(CSR_SCRATCH);
    localparam logic [14:0] QW_CTL       = csr_qw(CSR_CTL);
    localparam logic [14:0] QW_SRC_ADDR  = csr_qw(CSR_SRC_ADDR);
    localparam logic [14:0] QW_DST_ADDR  = csr_qw(CSR_DST_ADDR);
    localparam logic [14:0] QW_NUM_LINES = csr_qw(CSR_NUM_LINES);
    localparam logic [14:0] QW_STATUS    = csr_qw(CSR_STATUS);

    t_if_ccip_c0_Rx c0;
    logic           rd_valid, wr_en, wr_4b, wr_odd;
    logic [14:0]    qw;
    logic [63:0]    wr_data;

    assign c0       = cp2af_sRxPort.c0;
    assign rd_valid = c0.mmioRdValid;
    // A write colliding with a read is a protocol violation; the read wins.
    assign wr_en    = c0.mmioWrValid && !c0.mmioRdValid;
    assign qw       = c0.hdr.address[15:1];
    assign wr_odd   = c0.hdr.address[0];
    assign wr_4b    = (t_mmio_len'(c0.hdr.length) == MMIO_LEN_4B);
    assign wr_data  = c0.data[63:0];

    function automatic logic [63:0] merge_wr(input logic [63:0] cur, input logic [63:0] wd,
                                             input logic is_4b, input logic odd);
        if (!is_4b)  return wd;
        else if (odd) return {wd[31:0], cur[31:0]};
        else          return {cur[63:32], wd[31:0]};
    endfunction

    logic [63:0] scratch, ctl_q, src_q, dst_q;
    logic [31:0] nlines_q;
    logic        err_sticky, err_clr;
    logic [63:0] ctl_wr, nlines_wr;

    assign ctl_wr    = merge_wr(ctl_q, wr_data, wr_4b, wr_odd);
    assign nlines_wr = merge_wr({32'b0, nlines_q}, wr_data, wr_4b, wr_odd);
    assign err_clr   = wr_en && (qw == QW_STATUS) && !(wr_4b && wr_odd) && wr_data[STATUS_ERR_BIT];

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            scratch    <= '0;
            ctl_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            nlines_q   <= '0;
            err_sticky <= 1'b0;
            ctl_start  <= 1'b0;
        end else begin
            ctl_start <= 1'b0;
            if (wr_en) begin
                case (qw)
                    QW_SCRATCH:   scratch  <= merge_wr(scratch, wr_data, wr_4b, wr_odd);
                    QW_CTL: begin
                        ctl_q     <= {ctl_wr[63:1], 1'b0};
                        ctl_start <= ctl_wr[CTL_START_BIT];
                    end
                    QW_SRC_ADDR:  src_q    <= merge_wr(src_q, wr_data, wr_4b, wr_odd);
                    QW_DST_ADDR:  dst_q    <= merge_wr(dst_q, wr_data, wr_4b, wr_odd);
                    QW_NUM_LINES: nlines_q <= nlines_wr[31:0];
                    default: ;
                endcase
            end
            // Set has priority over a simultaneous clear.
            if (stat_err)     err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
        end
    end

`ifdef AFU_CSR_PERF_CNT_EN
    localparam logic [14:0] QW_CYCLE_CNT = csr_qw(CSR_CYCLE_CNT);
    localparam logic [14:0] QW_MMIO_CNT  = csr_qw(CSR_MMIO_CNT);

    logic [63:0] cycle_cnt;
    logic [31:0] rd_cnt, wr_cnt;

    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            cycle_cnt <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            if (wr_en && (qw == QW_CYCLE_CNT)) cycle_cnt <= '0;
            else                               cycle_cnt <= cycle_cnt + 64'd1;
            if (wr_en && (qw == QW_MMIO_CNT)) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                rd_cnt <= rd_cnt + {31'b0, rd_valid};
                wr_cnt <= wr_cnt + {31'b0, wr_en};
            end
        end
    end
`endif

    logic [63:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (qw)
            QW_DFH:       rd_data = AFU_DFH;
            QW_ID_L:      rd_data = AFU_ID_L;
            QW_ID_H:      rd_data = AFU_ID_H;
            QW_SCRATCH:   rd_data = scratch;
            QW_CTL:       rd_data = ctl_q;
            QW_SRC_ADDR:  rd_data = src_q;
            QW_DST_ADDR:  rd_data = dst_q;
            QW_NUM_LINES: rd_data = {32'b0, nlines_q};
            QW_STATUS: begin
                rd_data[STATUS_DONE_BIT] = stat_done;
                rd_data[STATUS_ERR_BIT]  = err_sticky;
            end
`ifdef AFU_CSR_PERF_CNT_EN
            QW_CYCLE_CNT: rd_data = cycle_cnt;
            // The read of MMIO_CNT reports itself in the read count.
            QW_MMIO_CNT:  rd_data = {wr_cnt, rd_cnt + 32'd1};
`endif
            default:      rd_data = '0;
        endcase
    end

    t_csr_rd_req rd_req;

    always_comb begin
        rd_req         = '0;
        rd_req.valid   = rd_valid;
        rd_req.tid     = c0.hdr.tid;
        rd_req.dw_addr = c0.hdr.address;
        rd_req.len     = t_mmio_len'(c0.hdr.length);
    end

    afu_mmio_rsp_pipe u_rsp_pipe (
        .clk     (Clk_400),
        .reset   (SoftReset),
        .rd_req  (rd_req),
        .rd_data (rd_data),
        .c2_tx   (mmio_c2Tx)
    );

    assign ctl_reg   = ctl_q;
    assign src_addr  = src_q;
    assign dst_addr  = dst_q;
    assign num_lines = nlines_q[NLINES_W-1:0];

    logic unused_rx;
    assign unused_rx = ^{cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c1TxAlmFull,
                         c0.hdr.rsvd, c0.data[511:64]};

endmodule

// File: tb/tb_afu_mmio_csr.sv
// Scoreboard bench for afu_mmio_csr: expected read responses queued at request time and
// compared (tid, data, arrival cycle) when the c2 response appears.
module tb_afu_mmio_csr;
    import afu_csr_pkg::*;

    localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;
    localparam logic [63:0] ID_L = 64'h1111_2222_3333_4444;
    localparam logic [63:0] ID_H = 64'h5555_6666_7777_8888;

    logic           Clk_400 = 1'b0;
    logic           SoftReset;
    t_if_ccip_Rx    rx;
    t_if_ccip_c2_Tx c2;
    logic           ctl_start;
    logic [63:0]    ctl_reg, src_addr, dst_addr;
    logic [31:0]    num_lines;
    logic           stat_done, stat_err;

    afu_mmio_csr #(
        .AFU_DFH  (DFH),
        .AFU_ID_L (ID_L),
        .AFU_ID_H (ID_H),
        .NLINES_W (32)
    ) dut (
        .Clk_400       (Clk_400),
        .SoftReset     (SoftReset),
        .cp2af_sRxPort (rx),
        .mmio_c2Tx     (c2),
        .ctl_start     (ctl_start),
        .ctl_reg       (ctl_reg),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .num_lines     (num_lines),
        .stat_done     (stat_done),
        .stat_err      (stat_err)
    );

    always #5 Clk_400 = ~Clk_400;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge Clk_400) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
    } t_exp;

    t_exp exp_q[$];

    always @(negedge Clk_400) begin
        if (c2.mmioRdValid) begin
            if (exp_q.size() == 0) begin
                check("rsp_extra", {55'b0, c2.hdr.tid}, 64'h1ff);
            end else begin
                t_exp e;
                e = exp_q.pop_front();
                check("rsp_tid", {55'b0, c2.hdr.tid}, {55'b0, e.tid});
                check("rsp_data", c2.data, e.data);
                check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic step();
        @(posedge Clk_400);
        #1;
    endtask

    task automatic mmio_rd(input logic [15:0] dw, input logic [1:0] len,
                           input logic [8:0] tid, input logic [63:0] exp);
        rx.c0.hdr.address = dw;
        rx.c0.hdr.length  = len;
        rx.c0.hdr.tid     = tid;
        rx.c0.mmioRdValid = 1'b1;
        exp_q.push_back('{tid: tid, data: exp, due: cyc + 2});
        step();
        rx.c0.mmioRdValid = 1'b0;
    endtask

    task automatic mmio_wr(input logic [15:0] dw, input logic [1:0] len, input logic [63:0] data);
        rx.c0.hdr.address = dw;
        rx.c0.hdr.length  = len;
        rx.c0.data        = {448'b0, data};
        rx.c0.mmioWrValid = 1'b1;
        step();
        rx.c0.mmioWrValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rx        = '0;
        stat_done = 1'b0;
        stat_err  = 1'b0;
        SoftReset = 1'b1;
        repeat (3) step();
        check("rst_rdvalid", {63'b0, c2.mmioRdValid}, 64'd0);
        check("rst_c2data", c2.data, 64'd0);
        check("rst_start", {63'b0, ctl_start}, 64'd0);
        check("rst_ctl", ctl_reg, 64'd0);
        check("rst_src", src_addr, 64'd0);
        check("rst_nlines", {32'b0, num_lines}, 64'd0);
        SoftReset = 1'b0;
        step();

        // Identification registers and reserved space
        mmio_rd(16'h0000, 2'd1, 9'd5, DFH);
        mmio_rd(16'h0002, 2'd1, 9'd6, ID_L);
        mmio_rd(16'h0004, 2'd1, 9'd7, ID_H);
        mmio_rd(16'h0006, 2'd1, 9'd8, 64'd0);
        mmio_rd(16'h0008, 2'd1, 9'd9, 64'd0);
        drain();

        // Scratch: 8B write, readback at N+1, DW selection, alignment, 64B length
        mmio_wr(16'h000A, 2'd1, 64'hDEAD_BEEF_0123_4567);
        mmio_rd(16'h000A, 2'd1, 9'd1, 64'hDEAD_BEEF_0123_4567);
        mmio_rd(16'h000B, 2'd0, 9'd2, 64'h0000_0000_DEAD_BEEF);
        mmio_rd(16'h000B, 2'd1, 9'd3, 64'hDEAD_BEEF_0123_4567);
        mmio_rd(16'h000A, 2'd2, 9'd4, 64'hDEAD_BEEF_0123_4567);
        mmio_wr(16'h000B, 2'd0, 64'hFFFF_FFFF_CAFE_F00D);
        mmio_rd(16'h000A, 2'd1, 9'd10, 64'hCAFE_F00D_0123_4567);
        mmio_wr(16'h000A, 2'd0, 64'h1234_5678_55AA_55AA);
        mmio_rd(16'h000A, 2'd0, 9'd11, 64'h0000_0000_55AA_55AA);
        mmio_rd(16'h000A, 2'd1, 9'd12, 64'hCAFE_F00D_55AA_55AA);
        mmio_rd(16'h0200, 2'd1, 9'd13, 64'd0);
        drain();

        // Writes to read-only and unmapped offsets are ignored
        mmio_wr(16'h0000, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        mmio_wr(16'h001C, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        mmio_rd(16'h0000, 2'd1, 9'd14, DFH);
        mmio_rd(16'h001C, 2'd1, 9'd15, 64'd0);
        drain();

        // CTL start pulse
        mmio_wr(16'h000C, 2'd1, 64'h3);
        check("ctl_start_hi", {63'b0, ctl_start}, 64'd1);
        check("ctl_reg", ctl_reg, 64'h2);
        step();
        check("ctl_start_lo", {63'b0, ctl_start}, 64'd0);
        mmio_rd(16'h000C, 2'd1, 9'd16, 64'h2);
        mmio_wr(16'h000C, 2'd1, 64'h1);
        check("ctl_start_again", {63'b0, ctl_start}, 64'd1);
        step();
        check("ctl_start_again_lo", {63'b0, ctl_start}, 64'd0);
        drain();

        // Datapath configuration outputs
        mmio_wr(16'h000E, 2'd1, 64'h0000_0001_2345_6780);
        mmio_wr(16'h0010, 2'd1, 64'h0000_0009_8765_4300);
        mmio_wr(16'h0012, 2'd1, 64'hFFFF_FFFF_0000_0040);
        check("src_addr", src_addr, 64'h0000_0001_2345_6780);
        check("dst_addr", dst_addr, 64'h0000_0009_8765_4300);
        check("num_lines", {32'b0, num_lines}, 64'h40);
        mmio_rd(16'h0012, 2'd1, 9'd17, 64'h40);
        drain();

        // Simultaneous read and write: read serviced, write dropped
        rx.c0.hdr.address = 16'h000A;
        rx.c0.hdr.length  = 2'd1;
        rx.c0.hdr.tid     = 9'd18;
        rx.c0.data        = {448'b0, 64'h0BAD_0BAD_0BAD_0BAD};
        rx.c0.mmioRdValid = 1'b1;
        rx.c0.mmioWrValid = 1'b1;
        exp_q.push_back('{tid: 9'd18, data: 64'hCAFE_F00D_55AA_55AA, due: cyc + 2});
        step();
        rx.c0.mmioRdValid = 1'b0;
        rx.c0.mmioWrValid = 1'b0;
        mmio_rd(16'h000A, 2'd1, 9'd19, 64'hCAFE_F00D_55AA_55AA);
        drain();

        // STATUS: level done, sticky error, set beats clear
        stat_done = 1'b1;
        mmio_rd(16'h0014, 2'd1, 9'd20, 64'h1);
        stat_err = 1'b1;
        mmio_wr(16'h0014, 2'd1, 64'h2);
        stat_err = 1'b0;
        mmio_rd(16'h0014, 2'd1, 9'd21, 64'h3);
        mmio_wr(16'h0014, 2'd1, 64'h2);
        mmio_rd(16'h0014, 2'd1, 9'd22, 64'h1);
        stat_done = 1'b0;
        stat_err  = 1'b1;
        step();
        stat_err  = 1'b0;
        mmio_rd(16'h0014, 2'd1, 9'd23, 64'h2);
        mmio_wr(16'h0014, 2'd1, 64'h2);
        mmio_rd(16'h0014, 2'd1, 9'd24, 64'h0);
        drain();

`ifdef AFU_CSR_PERF_CNT_EN
        mmio_wr(16'h0016, 2'd1, 64'h0);
        mmio_rd(16'h0016, 2'd1, 9'd25, 64'd0);
        mmio_rd(16'h0016, 2'd1, 9'd26, 64'd1);
        mmio_wr(16'h0018, 2'd1, 64'h0);
        mmio_rd(16'h000A, 2'd1, 9'd27, 64'hCAFE_F00D_55AA_55AA);
        mmio_rd(16'h0000, 2'd1, 9'd28, DFH);
        mmio_wr(16'h000E, 2'd1, 64'h0000_0001_2345_6780);
        mmio_wr(16'h0010, 2'd1, 64'h0000_0009_8765_4300);
        mmio_rd(16'h0018, 2'd1, 9'd29, {32'd2, 32'd3});
        drain();
`else
        mmio_rd(16'h0016, 2'd1, 9'd25, 64'd0);
        mmio_rd(16'h0018, 2'd1, 9'd26, 64'd0);
        mmio_wr(16'h0016, 2'd1, 64'h1234);
        mmio_rd(16'h0016, 2'd1, 9'd27, 64'd0);
        drain();
`endif

        // 16 back-to-back reads; scoreboard checks order and one-per-cycle arrival
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) mmio_rd(16'h0000, 2'd1, 9'(i), DFH);
            else            mmio_rd(16'h000B, 2'd0, 9'(i), 64'h0000_0000_CAFE_F00D);
        end
        drain();

        // Reset after the 8th request: tid 7 is still in flight and must be dropped
        for (int i = 0; i < 8; i++) begin
            mmio_rd(16'h0000, 2'd1, 9'(i), DFH);
        end
        SoftReset = 1'b1;
        repeat (4) step();
        check("rst_dropped", 64'(exp_q.size()), 64'd1);
        check("rst_mid_rdvalid", {63'b0, c2.mmioRdValid}, 64'd0);
        exp_q.delete();
        SoftReset = 1'b0;
        step();
        mmio_rd(16'h000A, 2'd1, 9'd30, 64'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
